cla_seq_ctrl: RTL and testbench
===============================

Name: cla_seq_ctrl

Overview:
Sequencing controller that performs wide additions (4*NIBBLES bits) by time-multiplexing one external 4-bit carry-lookahead adder cell (cla_4bit), one nibble per cycle, LSB nibble first. The inter-nibble carry is held in a register. Requests use a valid/ready handshake. The controller sits between a requester and the shared adder cell, which stays outside this block and is purely combinational.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES); legal range 1..16.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request operands valid
req_ready  out  1  controller can accept a request
req_a  in  W  operand A
req_b  in  W  operand B
req_cin  in  1  carry-in for the LSB nibble
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_sum  out  W  A+B+cin, low W bits
rsp_cout  out  1  carry out of the MSB nibble
rsp_ovf  out  1  two's-complement overflow
busy  out  1  high in RUN or DONE
cla_a  out  4  nibble of A to the adder cell
cla_b  out  4  nibble of B to the adder cell
cla_cin  out  1  carry to the adder cell
cla_s  in  4  adder cell sum
cla_cout  in  1  adder cell carry-out

Behaviour:
- Reset: one clock, synchronous active-high (clk, rst). On any edge with rst=1, the block goes to IDLE and clears a_reg, b_reg, sum_reg, carry_reg, idx, rsp_cout and rsp_ovf to 0. rsp_valid=0. busy=0. cla_a, cla_b and cla_cin are 0. rst has priority over all other events.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - cla_* outputs are driven to 0.
  - On req_valid&req_ready: latch req_a, req_b; carry_reg<=req_cin; idx<=0; go to RUN.
- RUN:
  - req_ready=0.
  - cla_a=a_reg[4*idx+:4], cla_b=b_reg[4*idx+:4], cla_cin=carry_reg.
  - Each edge: sum_reg[4*idx+:4]<=cla_s; carry_reg<=cla_cout; idx<=idx+1.
  - When idx==NIBBLES-1, on that edge:
    - rsp_cout<=cla_cout.
    - rsp_ovf<=(a_reg[W-1]==b_reg[W-1]) && (cla_s[3]!=a_reg[W-1]).
    - Go to DONE.
- DONE:
  - rsp_valid=1; rsp_sum=sum_reg. rsp_sum, rsp_cout and rsp_ovf are held stable while rsp_ready=0.
  - req_ready=0; cla_* outputs are 0.
  - On rsp_ready: go to IDLE.
- Throughput and latency:
  - No overlap between requests. The next request can be accepted in the cycle after the response handshake.
  - rsp_valid rises exactly NIBBLES edges after the accepting edge.
  - Throughput is at most one add per NIBBLES+2 cycles.
- NIBBLES=1: exactly one RUN cycle.
- req_a, req_b and req_cin are ignored outside the IDLE handshake. Changes to them during RUN have no effect.
- rsp_sum, rsp_cout and rsp_ovf are don't-care while rsp_valid=0. The bench checks them only when rsp_valid=1.
- Reset mid-RUN or mid-DONE: the operation is aborted. No response is produced, and the block is in IDLE (req_ready=1) in the cycle after rst deasserts.
- idx width is clog2(NIBBLES) (minimum 1). idx never exceeds NIBBLES-1.
- busy = (state!=IDLE).

Decomposition:
- Shared package cla_seq_pkg holds:
  - NIBBLE_W=4.
  - State enum type {IDLE, RUN, DONE}.
  - Helper function nibble index width clog2 (minimum 1).
- No sub-module is required. The adder cell is instantiated by the parent and by the bench, not inside the controller.
- Target implementation size: roughly 150 lines.

Test Plan:
All scenarios use NIBBLES=4 with cla_4bit connected to the cla_* ports.
1. A=0x1234, B=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0. rsp_valid is high exactly 4 edges after the accept edge.
2. A=0xFFFF, B=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. cla_cin is observed as 0,1,1,1 across the RUN cycles.
3. A=0x7FFF, B=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Also A=0x8000, B=0x8000 -> sum=0x0000, cout=1, ovf=1.
4. A=0x0000, B=0x0000, cin=1 -> sum=0x0001, cout=0. Back-to-back requests with req_valid held high: the second is accepted only on the cycle after the first rsp handshake. Throughput is checked at 6 cycles per add.
5. Backpressure: hold rsp_ready=0 for 3 cycles in DONE -> rsp_valid, rsp_sum and rsp_cout stay stable, req_ready=0, busy=1. Then release rsp_ready -> IDLE in the next cycle.
6. Assert rst for one cycle when idx=2 during RUN -> no rsp_valid ever appears for that request. Next cycle: req_ready=1, busy=0, cla_* outputs all 0. A subsequent request of 0x00FF+0x0001 returns 0x0100.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: slice width,
// controller states and the index-width helper.
package cla_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_seq_state_e;

  // Width of the nibble index; a single-nibble operand still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla_seq_ctrl.sv
// Time-multiplexes one external 4-bit carry-lookahead cell to add two
// 4*NIBBLES-bit operands, one nibble per cycle, LSB nibble first.
module cla_seq_ctrl
  import cla_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] req_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] req_b,
  input  logic                       req_cin,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] rsp_sum,
  output logic                       rsp_cout,
  output logic                       rsp_ovf,
  output logic                       busy,
  output logic [NIBBLE_W-1:0]        cla_a,
  output logic [NIBBLE_W-1:0]        cla_b,
  output logic                       cla_cin,
  input  logic [NIBBLE_W-1:0]        cla_s,
  input  logic                       cla_cout
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = idx_width(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]    state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_reg;
  logic          carry_reg;
  logic [IW-1:0] idx;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign rsp_sum   = sum_reg;

  // Operand slice steering to the shared cell; quiet outside RUN.
  always_comb begin
    cla_a   = '0;
    cla_b   = '0;
    cla_cin = 1'b0;
    if (state == ST_RUN) begin
      cla_cin = carry_reg;
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx == IW'(i)) begin
          cla_a = a_reg[NIBBLE_W*i +: NIBBLE_W];
          cla_b = b_reg[NIBBLE_W*i +: NIBBLE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            a_reg     <= req_a;
            b_reg     <= req_b;
            carry_reg <= req_cin;
            idx       <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) sum_reg[NIBBLE_W*i +: NIBBLE_W] <= cla_s;
          end
          carry_reg <= cla_cout;
          // Index wraps to 0 on the last slice so it never passes NIBBLES-1.
          if (idx == LAST_IDX) begin
            idx      <= '0;
            rsp_cout <= cla_cout;
            rsp_ovf  <= (a_reg[W-1] == b_reg[W-1]) && (cla_s[NIBBLE_W-1] != a_reg[W-1]);
            state    <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed and randomized bench for cla_seq_ctrl (NIBBLES=4) with a
// behavioural 4-bit adder cell on the cla_* ports.
module tb_cla_seq_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_ovf;
  logic         busy;
  logic [3:0]   cla_a;
  logic [3:0]   cla_b;
  logic         cla_cin;
  logic [3:0]   cla_s;
  logic         cla_cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign {cla_cout, cla_s} = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};

  cla_seq_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .busy(busy),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_s(cla_s), .cla_cout(cla_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the full operands.
  function automatic int ref_sum(input int a, input int b, input int cin);
    return a + b + cin;
  endfunction

  function automatic bit ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input bit cin);
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(cin);
    return (s > 32767) || (s < -32768);
  endfunction

  // Carry entering nibble i is the overflow of the low 4*i bits.
  function automatic bit ref_carry_in(input int a, input int b, input int cin, input int i);
    int m;
    m = (1 << (4 * i)) - 1;
    return 1'(((a & m) + (b & m) + cin) >> (4 * i));
  endfunction

  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input bit cin,
                         input string tag);
    int  cycles;
    int  s;
    bit  cq[$];
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_a = a; req_b = b; req_cin = cin; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    req_a = W'($urandom); req_b = W'($urandom); req_cin = 1'($urandom);
    cycles = 0;
    while (!rsp_valid && cycles < 20) begin
      if (busy) cq.push_back(cla_cin);
      req_a = W'($urandom);
      tick();
      cycles++;
    end
    check({tag, ".latency"}, 32'(cycles), 32'(N));
    check({tag, ".ncarry"}, 32'(cq.size()), 32'(N));
    for (int i = 0; i < N && i < cq.size(); i++)
      check($sformatf("%s.cin%0d", tag, i), 32'(cq[i]), 32'(ref_carry_in(int'(a), int'(b), int'(cin), i)));
    s = ref_sum(int'(a), int'(b), int'(cin));
    check({tag, ".sum"},  32'(rsp_sum),  32'(s & 16'hFFFF));
    check({tag, ".cout"}, 32'(rsp_cout), 32'((s >> 16) & 1));
    check({tag, ".ovf"},  32'(rsp_ovf),  32'(ref_ovf(a, b, cin)));
    check({tag, ".cla_idle"}, {27'd0, cla_a, cla_cin}, 32'd0);
    tick();
    check({tag, ".back_idle"}, {30'd0, req_ready, busy}, 32'd2);
  endtask

  initial begin
    int cycles;
    int acc_q[$];
    logic [W-1:0] hs;
    logic         hc;
    logic         saw_valid;

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_cin = 1'b0; rsp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset.ready", 32'(req_ready), 32'd1);
    check("reset.busy",  32'(busy), 32'd0);
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.cla", {23'd0, cla_a, cla_b, cla_cin}, 32'd0);

    run_add(16'h1234, 16'h4321, 1'b0, "t1");
    run_add(16'hFFFF, 16'h0001, 1'b0, "t2");
    run_add(16'h7FFF, 16'h0001, 1'b0, "t3a");
    run_add(16'h8000, 16'h8000, 1'b0, "t3b");
    run_add(16'h0000, 16'h0000, 1'b1, "t4");

    // Back-to-back with req_valid held high.
    req_valid = 1'b1; req_a = 16'h0000; req_b = 16'h0000; req_cin = 1'b1; rsp_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (req_ready) acc_q.push_back(c);
      if (rsp_valid) check("b2b.sum", 32'(rsp_sum), 32'h0001);
      tick();
    end
    req_valid = 1'b0;
    check("b2b.accepts", 32'(acc_q.size() >= 2), 32'd1);
    if (acc_q.size() >= 2) check("b2b.period", 32'(acc_q[1] - acc_q[0]), 32'd6);
    cycles = 0;
    while (!req_ready && cycles < 20) begin
      tick();
      cycles++;
    end
    check("b2b.drain", 32'(req_ready), 32'd1);

    // Backpressure in DONE.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_a = 16'hA5A5; req_b = 16'h1111; req_cin = 1'b1;
    tick();
    req_valid = 1'b0;
    cycles = 0;
    while (!rsp_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    check("bp.valid", 32'(rsp_valid), 32'd1);
    hs = rsp_sum; hc = rsp_cout;
    check("bp.sum", 32'(hs), 32'(ref_sum(32'hA5A5, 32'h1111, 1) & 16'hFFFF));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp.hold%0d", i),
            {13'd0, rsp_valid, rsp_sum, rsp_cout, req_ready, busy},
            {13'd0, 1'b1, hs, hc, 1'b0, 1'b1});
    end
    rsp_ready = 1'b1;
    tick();
    check("bp.release", {30'd0, req_ready, busy}, 32'd2);

    // Abort by reset while idx==2.
    req_valid = 1'b1; req_a = 16'h1357; req_b = 16'h2468; req_cin = 1'b0;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.idle", {30'd0, req_ready, busy}, 32'd2);
    check("abort.cla", {23'd0, cla_a, cla_b, cla_cin}, 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) saw_valid = 1'b1;
      tick();
    end
    check("abort.no_rsp", 32'(saw_valid), 32'd0);
    run_add(16'h00FF, 16'h0001, 1'b0, "abort.next");

    for (int k = 0; k < 10; k++)
      run_add(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rnd%0d", k));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
